// File: rtl/tmds_decoder_align_if.sv
// TMDS receive channel bundle: deserializer word in, decoded symbol and
// alignment status out. The decoder sits on the slave side.
interface tmds_decoder_align_if;
    logic [9:0] data;
    logic       de;
    logic       c0;
    logic       c1;
    logic [7:0] d;
    logic       locked;
    logic       bitslip;
    logic [3:0] slip_cnt;

    modport master (
        output data,
        input  de, c0, c1, d, locked, bitslip, slip_cnt
    );

    modport slave (
        input  data,
        output de, c0, c1, d, locked, bitslip, slip_cnt
    );
endinterface

// File: rtl/tmds_decoder_align.sv
// TMDS channel decoder with word-boundary alignment. Hunts for runs of
// control tokens, pulses bitslip to the deserializer after each fruitless
// search window, and once locked decodes words to DE/C0/C1/8-bit data.
module tmds_decoder_align #(
    parameter int LOCK_CNT      = 16,
    parameter int SEARCH_CYCLES = 2048,
    parameter int SLIP_WAIT     = 16,
    parameter int LOST_CYCLES   = 4096
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    tmds_decoder_align_if.slave  bus
);

    localparam int RUN_W  = $clog2(LOCK_CNT + 1);
    localparam int WIN_W  = $clog2(SEARCH_CYCLES + 1);
    localparam int WAIT_W = $clog2(SLIP_WAIT + 1);
    localparam int GAP_W  = $clog2(LOST_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_SLIP   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // Any of the four control tokens.
    function automatic logic token_hit(input logic [9:0] w);
        logic hit;
        case (w)
            10'b1101010100: hit = 1'b1;
            10'b0010101011: hit = 1'b1;
            10'b0101010100: hit = 1'b1;
            10'b1010101011: hit = 1'b1;
            default:        hit = 1'b0;
        endcase
        return hit;
    endfunction

    // Control bits {c1, c0} carried by a token; zero for non-tokens.
    function automatic logic [1:0] token_ctl(input logic [9:0] w);
        logic [1:0] ctl;
        case (w)
            10'b1101010100: ctl = 2'b00;
            10'b0010101011: ctl = 2'b01;
            10'b0101010100: ctl = 2'b10;
            10'b1010101011: ctl = 2'b11;
            default:        ctl = 2'b00;
        endcase
        return ctl;
    endfunction

    // Undo the conditional inversion, then the XOR/XNOR transition chain.
    function automatic logic [7:0] tmds_decode(input logic [9:0] w);
        logic [7:0] t;
        logic [7:0] dec;
        t      = w[9] ? ~w[7:0] : w[7:0];
        dec[0] = t[0];
        for (int i = 1; i < 8; i++) begin
            dec[i] = w[8] ? (t[i] ^ t[i-1]) : ~(t[i] ^ t[i-1]);
        end
        return dec;
    endfunction

    state_t              state_r;
    logic [RUN_W-1:0]    run_cnt_r;
    logic [WIN_W-1:0]    win_cnt_r;
    logic [WAIT_W-1:0]   wait_cnt_r;
    logic [GAP_W-1:0]    gap_cnt_r;
    logic [3:0]          slip_cnt_r;
    logic                bitslip_r;
    logic                locked_r;
    logic                de_r;
    logic                c0_r;
    logic                c1_r;
    logic [7:0]          d_r;

    logic                tok_s;
    logic [1:0]          ctl_s;
    logic [7:0]          dec_s;

    // Classify and decode the incoming word.
    always_comb begin
        tok_s = token_hit(bus.data);
        ctl_s = token_ctl(bus.data);
        dec_s = tmds_decode(bus.data);
    end

    // Alignment FSM with its counters and the gated, registered decode outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r    <= ST_SEARCH;
            run_cnt_r  <= '0;
            win_cnt_r  <= '0;
            wait_cnt_r <= '0;
            gap_cnt_r  <= '0;
            slip_cnt_r <= 4'd0;
            bitslip_r  <= 1'b0;
            locked_r   <= 1'b0;
            de_r       <= 1'b0;
            c0_r       <= 1'b0;
            c1_r       <= 1'b0;
            d_r        <= 8'd0;
        end else begin
            bitslip_r <= 1'b0;
            case (state_r)
                ST_SEARCH: begin
                    de_r <= 1'b0;
                    c0_r <= 1'b0;
                    c1_r <= 1'b0;
                    d_r  <= 8'd0;
                    // Lock takes priority over window expiry on the same cycle.
                    if (tok_s && (run_cnt_r == RUN_W'(LOCK_CNT - 1))) begin
                        state_r   <= ST_LOCKED;
                        locked_r  <= 1'b1;
                        run_cnt_r <= '0;
                        gap_cnt_r <= '0;
                        win_cnt_r <= '0;
                    end else if (win_cnt_r == WIN_W'(SEARCH_CYCLES - 1)) begin
                        state_r    <= ST_SLIP;
                        bitslip_r  <= 1'b1;
                        slip_cnt_r <= (slip_cnt_r == 4'd9) ? 4'd0 : slip_cnt_r + 4'd1;
                        win_cnt_r  <= '0;
                        run_cnt_r  <= '0;
                        wait_cnt_r <= '0;
                    end else begin
                        win_cnt_r <= win_cnt_r + WIN_W'(1);
                        run_cnt_r <= tok_s ? run_cnt_r + RUN_W'(1) : '0;
                    end
                end
                ST_SLIP: begin
                    de_r <= 1'b0;
                    c0_r <= 1'b0;
                    c1_r <= 1'b0;
                    d_r  <= 8'd0;
                    // Deserializer output is unreliable while it settles.
                    if (wait_cnt_r == WAIT_W'(SLIP_WAIT - 1)) begin
                        state_r    <= ST_SEARCH;
                        wait_cnt_r <= '0;
                        win_cnt_r  <= '0;
                        run_cnt_r  <= '0;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
                    end
                end
                ST_LOCKED: begin
                    if (tok_s) begin
                        de_r      <= 1'b0;
                        c0_r      <= ctl_s[0];
                        c1_r      <= ctl_s[1];
                        d_r       <= 8'd0;
                        gap_cnt_r <= '0;
                    end else begin
                        // Sync bits keep their last token value through video.
                        de_r <= 1'b1;
                        d_r  <= dec_s;
                        if (gap_cnt_r == GAP_W'(LOST_CYCLES - 1)) begin
                            state_r   <= ST_SEARCH;
                            locked_r  <= 1'b0;
                            gap_cnt_r <= '0;
                            win_cnt_r <= '0;
                            run_cnt_r <= '0;
                        end else begin
                            gap_cnt_r <= gap_cnt_r + GAP_W'(1);
                        end
                    end
                end
                default: begin
                    state_r    <= ST_SEARCH;
                    run_cnt_r  <= '0;
                    win_cnt_r  <= '0;
                    wait_cnt_r <= '0;
                    gap_cnt_r  <= '0;
                    locked_r   <= 1'b0;
                    de_r       <= 1'b0;
                    c0_r       <= 1'b0;
                    c1_r       <= 1'b0;
                    d_r        <= 8'd0;
                end
            endcase
        end
    end

    assign bus.de       = de_r;
    assign bus.c0       = c0_r;
    assign bus.c1       = c1_r;
    assign bus.d        = d_r;
    assign bus.locked   = locked_r;
    assign bus.bitslip  = bitslip_r;
    assign bus.slip_cnt = slip_cnt_r;

endmodule

// File: tb/tb_tmds_decoder_align.sv
// Self-checking bench for tmds_decoder_align: random TMDS traffic from an
// encoder model, a rotating deserializer model, and timing expectations
// derived arithmetically from the search/slip/lock rules.
module tb_tmds_decoder_align;

    localparam int SC   = 2048;          // search window
    localparam int SW   = 16;            // slip settle
    localparam int PER  = SC + SW;       // bitslip spacing
    localparam int LOST = 4096;

    localparam logic [9:0] C00 = 10'b1101010100;
    localparam logic [9:0] C01 = 10'b0010101011;
    localparam logic [9:0] C10 = 10'b0101010100;
    localparam logic [9:0] C11 = 10'b1010101011;

    logic clk_i = 1'b0;
    logic rst_ni;
    int   vectors = 0;
    int   miscompares = 0;

    tmds_decoder_align_if bus ();

    tmds_decoder_align dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic is_ctl(input logic [9:0] w);
        return (w == C00) || (w == C01) || (w == C10) || (w == C11);
    endfunction

    // Transition-minimising stage plus optional inversion, choices given.
    function automatic logic [9:0] encode(input logic [7:0] v, input logic inv, input logic xr);
        logic [7:0] q;
        q[0] = v[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = xr ? (v[i] ^ q[i-1]) : ~(v[i] ^ q[i-1]);
        end
        return {inv, xr, inv ? ~q : q};
    endfunction

    // Word as seen by a deserializer whose boundary is k bits off.
    function automatic logic [9:0] rot(input logic [9:0] w, input int k);
        logic [19:0] dd;
        dd = {w, w};
        return dd[k +: 10];
    endfunction

    // Random legal data word and the byte it carries.
    task automatic gen_word(output logic [9:0] w, output logic [7:0] v);
        w = 10'd0;
        v = 8'd0;
        for (int t = 0; t < 32; t++) begin
            v = 8'($urandom);
            w = encode(v, 1'($urandom), 1'($urandom));
            if (!is_ctl(w)) break;
        end
        if (is_ctl(w)) begin
            v = 8'd0;
            w = encode(v, 1'b0, 1'b1);
        end
    endtask

    // One word per clock; outputs are examined 1 ns after the edge.
    task automatic drive(input logic [9:0] w);
        bus.data = w;
        @(posedge clk_i);
        #1;
    endtask

    task automatic apply_reset();
        rst_ni   = 1'b0;
        bus.data = 10'($urandom);
        repeat (3) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        logic [9:0] w;
        logic [7:0] v;
        rst_ni = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.data = 10'($urandom);
            @(posedge clk_i);
            #1;
            vectors++;
            if ({bus.de, bus.c0, bus.c1, bus.d, bus.locked, bus.bitslip, bus.slip_cnt} !== 17'd0) begin
                miscompares++;
                $display("FAIL reset_outputs: got %h want 0",
                         {bus.de, bus.c0, bus.c1, bus.d, bus.locked, bus.bitslip, bus.slip_cnt});
            end
        end
        rst_ni = 1'b1;
        for (int i = 0; i < 40; i++) begin
            gen_word(w, v);
            drive(w);
            vectors++;
            if ({bus.locked, bus.de, bus.d} !== 10'd0) begin
                miscompares++;
                $display("FAIL reset_release cycle %0d: got %h want 0", i, {bus.locked, bus.de, bus.d});
            end
        end
    endtask

    task automatic test_aligned();
        logic [9:0] toks [4];
        logic [9:0] w;
        logic [7:0] v;
        logic       exp_de, exp_c0, exp_c1;
        logic [7:0] exp_d;
        int         k;
        toks = '{C00, C01, C10, C11};
        apply_reset();
        for (int i = 1; i <= 20; i++) begin
            drive(C00);
            vectors++;
            if (bus.locked !== (i >= 16)) begin
                miscompares++;
                $display("FAIL aligned_lock token %0d: got %b want %b", i, bus.locked, (i >= 16));
            end
            vectors++;
            if ({bus.de, bus.c0, bus.c1, bus.d} !== 11'd0) begin
                miscompares++;
                $display("FAIL aligned_ctl token %0d: got %h want 0", i, {bus.de, bus.c0, bus.c1, bus.d});
            end
        end
        drive(encode(8'h5A, 1'b0, 1'b1));
        vectors++;
        if ({bus.locked, bus.de, bus.c1, bus.c0, bus.d} !== {1'b1, 1'b1, 1'b0, 1'b0, 8'h5A}) begin
            miscompares++;
            $display("FAIL aligned_5a: got %h want %h", {bus.locked, bus.de, bus.c1, bus.c0, bus.d},
                     {1'b1, 1'b1, 1'b0, 1'b0, 8'h5A});
        end
        exp_c0 = 1'b0;
        exp_c1 = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(3, 0) == 0) begin
                k      = int'($urandom_range(3, 0));
                w      = toks[k];
                exp_de = 1'b0;
                exp_d  = 8'd0;
                exp_c0 = (k == 1) || (k == 3);
                exp_c1 = (k >= 2);
            end else begin
                gen_word(w, v);
                exp_de = 1'b1;
                exp_d  = v;
            end
            drive(w);
            vectors++;
            if ({bus.locked, bus.de, bus.c1, bus.c0, bus.d, bus.bitslip} !==
                {1'b1, exp_de, exp_c1, exp_c0, exp_d, 1'b0}) begin
                miscompares++;
                $display("FAIL locked_mix %0d word %h: got %h want %h", i, w,
                         {bus.locked, bus.de, bus.c1, bus.c0, bus.d, bus.bitslip},
                         {1'b1, exp_de, exp_c1, exp_c0, exp_d, 1'b0});
            end
        end
    endtask

    task automatic test_sync_decode();
        logic [9:0] w;
        logic [7:0] v;
        apply_reset();
        repeat (16) drive(C00);
        drive(C11);
        vectors++;
        if ({bus.c0, bus.c1, bus.de, bus.d} !== {1'b1, 1'b1, 1'b0, 8'd0}) begin
            miscompares++;
            $display("FAIL sync_c11: got %h want %h", {bus.c0, bus.c1, bus.de, bus.d}, {1'b1, 1'b1, 1'b0, 8'd0});
        end
        gen_word(w, v);
        drive(w);
        vectors++;
        if ({bus.c0, bus.c1, bus.de, bus.d} !== {1'b1, 1'b1, 1'b1, v}) begin
            miscompares++;
            $display("FAIL sync_hold: got %h want %h", {bus.c0, bus.c1, bus.de, bus.d}, {1'b1, 1'b1, 1'b1, v});
        end
        drive(C01);
        vectors++;
        if ({bus.c0, bus.c1, bus.de} !== 3'b100) begin
            miscompares++;
            $display("FAIL sync_c01: got %b want 100", {bus.c0, bus.c1, bus.de});
        end
    endtask

    task automatic test_misalign();
        int   off;
        int   seen;
        int   lock_e;
        logic exp_bs;
        off    = 3;
        seen   = 0;
        lock_e = SC + 6 * PER + 2 * SW;
        apply_reset();
        for (int e = 1; e <= lock_e + 16; e++) begin
            drive(rot(C00, off));
            exp_bs = (e >= SC) && (((e - SC) % PER) == 0) && (((e - SC) / PER) < 7);
            vectors++;
            if (bus.bitslip !== exp_bs) begin
                miscompares++;
                $display("FAIL misalign_bitslip edge %0d: got %b want %b", e, bus.bitslip, exp_bs);
            end
            vectors++;
            if (bus.locked !== (e >= lock_e)) begin
                miscompares++;
                $display("FAIL misalign_locked edge %0d: got %b want %b", e, bus.locked, (e >= lock_e));
            end
            if (bus.bitslip === 1'b1) begin
                off = (off + 1) % 10;
                seen++;
            end
        end
        vectors++;
        if (seen != 7) begin
            miscompares++;
            $display("FAIL misalign_pulses: got %0d want 7", seen);
        end
        vectors++;
        if (bus.slip_cnt !== 4'd7) begin
            miscompares++;
            $display("FAIL misalign_slip_cnt: got %0d want 7", bus.slip_cnt);
        end
    endtask

    task automatic test_slip_wrap();
        logic [9:0] w;
        logic [7:0] v;
        int         npulse;
        logic       exp_bs;
        apply_reset();
        for (int e = 1; e <= SC + 10 * PER + 8; e++) begin
            gen_word(w, v);
            drive(w);
            exp_bs = (e >= SC) && (((e - SC) % PER) == 0);
            npulse = (e < SC) ? 0 : ((e - SC) / PER + 1);
            vectors++;
            if ({bus.bitslip, bus.slip_cnt, bus.locked, bus.de} !== {exp_bs, 4'(npulse % 10), 1'b0, 1'b0}) begin
                miscompares++;
                $display("FAIL wrap edge %0d: got %h want %h", e,
                         {bus.bitslip, bus.slip_cnt, bus.locked, bus.de},
                         {exp_bs, 4'(npulse % 10), 1'b0, 1'b0});
            end
        end
    endtask

    task automatic test_simul_lock();
        logic [9:0] w;
        logic [7:0] v;
        apply_reset();
        for (int e = 1; e <= SC + 20; e++) begin
            if (e > SC - 16) begin
                w = C00;
            end else begin
                gen_word(w, v);
            end
            drive(w);
            vectors++;
            if ({bus.bitslip, bus.locked, bus.slip_cnt} !== {1'b0, (e >= SC), 4'd0}) begin
                miscompares++;
                $display("FAIL simul edge %0d: got %h want %h", e,
                         {bus.bitslip, bus.locked, bus.slip_cnt}, {1'b0, (e >= SC), 4'd0});
            end
        end
    endtask

    task automatic test_lock_loss();
        logic [9:0] w;
        logic [7:0] v;
        apply_reset();
        repeat (16) drive(C00);
        drive(C10);
        for (int k = 1; k <= 3000; k++) begin
            gen_word(w, v);
            drive(w);
            vectors++;
            if ({bus.locked, bus.de, bus.c1, bus.c0, bus.d} !== {1'b1, 1'b1, 1'b1, 1'b0, v}) begin
                miscompares++;
                $display("FAIL gap_pre %0d: got %h want %h", k,
                         {bus.locked, bus.de, bus.c1, bus.c0, bus.d}, {1'b1, 1'b1, 1'b1, 1'b0, v});
            end
        end
        drive(C10);
        for (int k = 1; k <= LOST; k++) begin
            gen_word(w, v);
            drive(w);
            vectors++;
            if ({bus.locked, bus.de, bus.c1, bus.d} !== {(k < LOST), 1'b1, 1'b1, v}) begin
                miscompares++;
                $display("FAIL loss word %0d: got %h want %h", k,
                         {bus.locked, bus.de, bus.c1, bus.d}, {(k < LOST), 1'b1, 1'b1, v});
            end
        end
        gen_word(w, v);
        drive(w);
        vectors++;
        if ({bus.locked, bus.de, bus.c0, bus.c1, bus.d} !== 12'd0) begin
            miscompares++;
            $display("FAIL loss_gated: got %h want 0", {bus.locked, bus.de, bus.c0, bus.c1, bus.d});
        end
    endtask

    task automatic test_reset_mid();
        logic [9:0] w;
        logic [7:0] v;
        apply_reset();
        for (int e = 1; e <= SC + 5; e++) begin
            gen_word(w, v);
            drive(w);
        end
        vectors++;
        if (bus.slip_cnt !== 4'd1) begin
            miscompares++;
            $display("FAIL mid_pre_slip: got %0d want 1", bus.slip_cnt);
        end
        #2;
        rst_ni = 1'b0;
        #1;
        vectors++;
        if ({bus.slip_cnt, bus.bitslip, bus.locked, bus.de} !== 7'd0) begin
            miscompares++;
            $display("FAIL mid_async: got %h want 0", {bus.slip_cnt, bus.bitslip, bus.locked, bus.de});
        end
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        for (int e = 1; e <= SC + 4; e++) begin
            gen_word(w, v);
            drive(w);
            vectors++;
            if ({bus.bitslip, bus.slip_cnt} !== {(e == SC), 4'((e >= SC) ? 1 : 0)}) begin
                miscompares++;
                $display("FAIL mid_restart edge %0d: got %h want %h", e,
                         {bus.bitslip, bus.slip_cnt}, {(e == SC), 4'((e >= SC) ? 1 : 0)});
            end
        end
    endtask

    initial begin
        rst_ni   = 1'b0;
        bus.data = 10'd0;
        test_reset();
        test_aligned();
        test_sync_decode();
        test_misalign();
        test_slip_wrap();
        test_simul_lock();
        test_lock_loss();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
